// File: rtl/xb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : xb_pkg
//  Purpose  : Shared widths, compute-unit indices and helpers for xb_regfile.
//  Revision : 1.0 - initial release
// ============================================================================
package xb_pkg;

    localparam int XB_W    = 16;
    localparam int XB_NREG = 16;
    localparam int XB_AW   = 4;
    localparam int XB_NCU  = 3;

    localparam int CU_ALU  = 0;
    localparam int CU_MUL  = 1;
    localparam int CU_SHF  = 2;

    typedef logic [XB_AW-1:0]  xb_addr_t;
    typedef logic [XB_NCU-1:0] xb_cuen_t;

    // True when two or more compute units claim the write port at once.
    function automatic logic xb_multi_hot(input xb_cuen_t en);
        return (en & (en - xb_cuen_t'(1))) != '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xb_wsel.sv
`default_nettype none
// ============================================================================
//  Module   : xb_wsel
//  Purpose  : Priority write-data select (ALU > MUL > SHF) with multi-hot flag.
//  Revision : 1.0 - initial release
// ============================================================================
module xb_wsel
    import xb_pkg::*;
#(
    parameter int W = XB_W
) (
    input  logic [XB_NCU-1:0] i_cu_en,
    input  logic [W-1:0]      i_alu_res,
    input  logic [W-1:0]      i_mul_res,
    input  logic [W-1:0]      i_shf_res,
    output logic [W-1:0]      o_wd,
    output logic              o_wr_vld,
    output logic              o_multi
);

    always_comb begin
        o_wd = '0;
        if (i_cu_en[CU_ALU]) begin
            o_wd = i_alu_res;
        end else if (i_cu_en[CU_MUL]) begin
            o_wd = i_mul_res;
        end else if (i_cu_en[CU_SHF]) begin
            o_wd = i_shf_res;
        end
    end

    assign o_wr_vld = |i_cu_en;
    assign o_multi  = xb_multi_hot(i_cu_en);

endmodule
`default_nettype wire

// File: rtl/xb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : xb_regfile
//  Purpose  : 16-entry register file with two registered read ports, a single
//             unit-selected write-back and same-cycle write-to-read bypass.
//  Revision : 1.0 - initial release
// ============================================================================
module xb_regfile
    import xb_pkg::*;
#(
    parameter int WRT = XB_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XB_AW-1:0]  ps_xb_rd_a0,
    input  logic [XB_AW-1:0]  ps_xb_raddy,
    input  logic [XB_AW-1:0]  ps_xb_wrt_a,
    input  logic [XB_NCU-1:0] ps_xb_w_cuEn,
    input  logic [WRT-1:0]    alu_xb_res,
    input  logic [WRT-1:0]    mul_xb_res,
    input  logic [WRT-1:0]    shf_xb_res,
    output logic [WRT-1:0]    xb_dtx,
    output logic [WRT-1:0]    xb_dty,
    output logic              xb_wr_err
);

    logic [WRT-1:0]   r_regs [XB_NREG];
    logic [XB_AW-1:0] r_wa_q;
    logic [WRT-1:0]   r_dtx;
    logic [WRT-1:0]   r_dty;
    logic             r_wr_err;

    logic [WRT-1:0]   w_wd;
    logic             w_wr_vld;
    logic             w_multi;
    logic [WRT-1:0]   w_dtx_nxt;
    logic [WRT-1:0]   w_dty_nxt;

    xb_wsel #(
        .W (WRT)
    ) u_wsel (
        .i_cu_en   (ps_xb_w_cuEn),
        .i_alu_res (alu_xb_res),
        .i_mul_res (mul_xb_res),
        .i_shf_res (shf_xb_res),
        .o_wd      (w_wd),
        .o_wr_vld  (w_wr_vld),
        .o_multi   (w_multi)
    );

    // The write lands at the same edge the operands are captured, so a match
    // must take the incoming data rather than the stale array entry.
    assign w_dtx_nxt = (w_wr_vld && (r_wa_q == ps_xb_rd_a0)) ? w_wd : r_regs[ps_xb_rd_a0];
    assign w_dty_nxt = (w_wr_vld && (r_wa_q == ps_xb_raddy)) ? w_wd : r_regs[ps_xb_raddy];

    // Write address is decoded one cycle ahead of its enables.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wa_q <= '0;
        end else begin
            r_wa_q <= ps_xb_wrt_a;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < XB_NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_vld) begin
            r_regs[r_wa_q] <= w_wd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dtx <= '0;
            r_dty <= '0;
        end else begin
            r_dtx <= w_dtx_nxt;
            r_dty <= w_dty_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_err <= 1'b0;
        end else if (w_multi) begin
            r_wr_err <= 1'b1;
        end
    end

    assign xb_dtx    = r_dtx;
    assign xb_dty    = r_dty;
    assign xb_wr_err = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_xb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xb_regfile
//  Purpose  : Self-checking bench for xb_regfile with a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_xb_regfile;
    import xb_pkg::*;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic [3:0]  rd_a0 = '0;
    logic [3:0]  raddy = '0;
    logic [3:0]  wrt_a = '0;
    logic [2:0]  cu_en = '0;
    logic [15:0] alu   = '0;
    logic [15:0] mul   = '0;
    logic [15:0] shf   = '0;
    logic [15:0] dtx;
    logic [15:0] dty;
    logic        wr_err;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    logic [15:0] mem [16];
    logic [3:0]  wa_prev;
    logic [15:0] exp_x;
    logic [15:0] exp_y;
    logic        exp_err;

    xb_regfile #(
        .WRT (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ps_xb_rd_a0  (rd_a0),
        .ps_xb_raddy  (raddy),
        .ps_xb_wrt_a  (wrt_a),
        .ps_xb_w_cuEn (cu_en),
        .alu_xb_res   (alu),
        .mul_xb_res   (mul),
        .shf_xb_res   (shf),
        .xb_dtx       (dtx),
        .xb_dty       (dty),
        .xb_wr_err    (wr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a write issued this cycle is visible to reads captured at the same
    // edge, so the array is updated first and then simply read.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) mem[i] = '0;
            wa_prev = '0;
            exp_x   = '0;
            exp_y   = '0;
            exp_err = 1'b0;
        end else begin
            if (cu_en != 3'b000)
                mem[wa_prev] = cu_en[0] ? alu : (cu_en[1] ? mul : shf);
            if ($countones(cu_en) > 1)
                exp_err = 1'b1;
            exp_x   = mem[rd_a0];
            exp_y   = mem[raddy];
            wa_prev = wrt_a;
        end
        #1;
        if (chk_en) begin
            chk("cyc_dtx", dtx, exp_x);
            chk("cyc_dty", dty, exp_y);
            chk("cyc_err", {15'd0, wr_err}, {15'd0, exp_err});
        end
    end

    task automatic cyc(input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] wa,
                       input logic [2:0] cu, input logic [15:0] a, input logic [15:0] m,
                       input logic [15:0] s);
        @(negedge clk);
        rd_a0 = ra;
        raddy = rb;
        wrt_a = wa;
        cu_en = cu;
        alu   = a;
        mul   = m;
        shf   = s;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1 rst = 1'b0;
        #1 chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b1;

        // Preload R5 and set the sticky error, then reset mid-cycle
        cyc(0, 0, 5, 3'b000, 0, 0, 0);
        cyc(0, 0, 0, 3'b001, 16'h1234, 0, 0);
        cyc(5, 5, 0, 3'b000, 0, 0, 0);
        chk("preload_r5", dtx, 16'h1234);
        cyc(0, 0, 6, 3'b000, 0, 0, 0);
        cyc(0, 0, 0, 3'b011, 16'h0AAA, 16'h0BBB, 0);
        chk("multi_err_set", {15'd0, wr_err}, 16'd1);
        cyc(6, 0, 0, 3'b000, 0, 0, 0);
        chk("multi_alu_wins", dtx, 16'h0AAA);
        #1 rst = 1'b0;
        #1;
        chk("rst_dtx", dtx, 16'h0000);
        chk("rst_dty", dty, 16'h0000);
        chk("rst_err", {15'd0, wr_err}, 16'd0);
        cyc(5, 5, 0, 3'b000, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        cyc(5, 5, 0, 3'b000, 0, 0, 0);
        chk("rst_r5_cleared", dtx, 16'h0000);

        // ALU write then read two cycles later
        cyc(0, 0, 3, 3'b000, 0, 0, 0);
        cyc(0, 0, 0, 3'b001, 16'hA5A5, 16'h5555, 16'h6666);
        cyc(0, 0, 0, 3'b000, 0, 0, 0);
        cyc(3, 0, 0, 3'b000, 0, 0, 0);
        chk("alu_rd_r3", dtx, 16'hA5A5);

        // Same-cycle bypass on both ports
        cyc(0, 0, 7, 3'b000, 0, 0, 0);
        cyc(7, 7, 0, 3'b010, 16'hDEAD, 16'h00FF, 16'hBEEF);
        chk("bypass_dtx", dtx, 16'h00FF);
        chk("bypass_dty", dty, 16'h00FF);
        cyc(7, 7, 0, 3'b000, 0, 0, 0);
        chk("bypass_array", dtx, 16'h00FF);

        // Priority MUL over SHF, sticky error
        cyc(0, 0, 9, 3'b000, 0, 0, 0);
        cyc(0, 0, 0, 3'b110, 16'h7777, 16'h1111, 16'h2222);
        chk("prio_err", {15'd0, wr_err}, 16'd1);
        cyc(9, 0, 0, 3'b000, 0, 0, 0);
        chk("prio_r9", dtx, 16'h1111);
        chk("err_sticky", {15'd0, wr_err}, 16'd1);

        // Write address pairs with the previous cycle's decode
        cyc(0, 0, 4, 3'b000, 0, 0, 0);
        cyc(0, 0, 12, 3'b001, 16'hBEEF, 0, 0);
        cyc(0, 0, 0, 3'b000, 0, 0, 0);
        cyc(4, 12, 0, 3'b000, 0, 0, 0);
        chk("align_r4", dtx, 16'hBEEF);
        chk("align_r12", dty, 16'h0000);

        // No enables: results toggle, array must hold
        for (int i = 0; i < 10; i++)
            cyc(4'($urandom), 4'($urandom), 4'($urandom), 3'b000,
                16'($urandom), 16'($urandom), 16'($urandom));
        cyc(3, 7, 0, 3'b000, 0, 0, 0);
        chk("hold_r3", dtx, 16'hA5A5);
        chk("hold_r7", dty, 16'h00FF);
        cyc(9, 4, 0, 3'b000, 0, 0, 0);
        chk("hold_r9", dtx, 16'h1111);
        chk("hold_r4", dty, 16'hBEEF);

        // Randomized traffic, biased toward back-to-back dependencies
        for (int i = 0; i < 2000; i++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            logic [2:0] cu;
            int         sel;
            ra  = ($urandom_range(0, 2) == 0) ? wrt_a : 4'($urandom);
            rb  = ($urandom_range(0, 2) == 0) ? wrt_a : 4'($urandom);
            sel = $urandom_range(0, 15);
            if (sel < 5)       cu = 3'b000;
            else if (sel < 14) cu = 3'b001 << $urandom_range(0, 2);
            else               cu = 3'($urandom);
            cyc(ra, rb, 4'($urandom), cu, 16'($urandom), 16'($urandom), 16'($urandom));
        end

        cyc(0, 0, 0, 3'b000, 0, 0, 0);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
